uart_upload_controller: RTL and testbench



---
 rtl/uart_upload_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_upload_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_upload_controller.sv
// uart_upload_controller
// Steers the uart_unit write stream into instruction or data memory and owns
// the CPU-mode / upload-mode switch.
//
// Ports:
//   clk, rst_n          system clock (shared with uart_unit), async active-low reset
//   mode_btn            raw upload-request button (synchronised + debounced here)
//   uart_write_enable   level, high while uart_addr/uart_data hold a valid word
//   uart_addr           word address; MSB 0 = imem, 1 = dmem
//   uart_data           write data word
//   uart_complete       level, high once the upload is done
//   uart_disable        holds uart_unit in reset while high
//   imem_we / dmem_we   single-cycle memory write strobes
//   mem_addr / mem_data registered write address / data
//   cpu_rst             active-high CPU hold
//   upload_active       high while in UPLOAD or DRAIN
//   word_count          words written in the current/last upload (saturating)
module uart_upload_controller #(
    parameter int unsigned RAM_DEPTH       = 14,
    parameter int unsigned ISA_WIDTH       = 32,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
    parameter logic [7:0]  CPU_RST_HOLD    = 8'd16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode_btn,
    input  logic                 uart_write_enable,
    input  logic [RAM_DEPTH:0]   uart_addr,
    input  logic [ISA_WIDTH-1:0] uart_data,
    input  logic                 uart_complete,
    output logic                 uart_disable,
    output logic                 imem_we,
    output logic                 dmem_we,
    output logic [RAM_DEPTH-1:0] mem_addr,
    output logic [ISA_WIDTH-1:0] mem_data,
    output logic                 cpu_rst,
    output logic                 upload_active,
    output logic [15:0]          word_count
);

    localparam int unsigned DEB_W  = 20;
    localparam int unsigned HOLD_W = 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_UPLOAD = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t               r_state, w_state_nx;

    logic                 r_btn_meta, r_btn_sync;
    logic [DEB_W-1:0]     r_deb_cnt;
    logic                 r_deb_fired;
    logic                 w_btn_req;

    logic                 r_we_prev;
    logic                 w_wr_edge;

    logic [HOLD_W-1:0]    r_hold_cnt, w_hold_cnt_nx;
    logic                 r_por_hold, w_por_hold_nx;

    logic                 r_uart_disable, w_uart_disable_nx;
    logic                 r_imem_we, w_imem_we_nx;
    logic                 r_dmem_we, w_dmem_we_nx;
    logic [RAM_DEPTH-1:0] r_mem_addr, w_mem_addr_nx;
    logic [ISA_WIDTH-1:0] r_mem_data, w_mem_data_nx;
    logic                 r_cpu_rst, w_cpu_rst_nx;
    logic                 r_upload_active, w_upload_active_nx;
    logic [CNT_W-1:0]     r_word_count, w_word_count_nx;

    // Button synchroniser and debounce: one request per stable-high press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_meta  <= 1'b0;
            r_btn_sync  <= 1'b0;
            r_deb_cnt   <= '0;
            r_deb_fired <= 1'b0;
        end else begin
            r_btn_meta <= mode_btn;
            r_btn_sync <= r_btn_meta;
            if (!r_btn_sync) begin
                r_deb_cnt   <= '0;
                r_deb_fired <= 1'b0;
            end else begin
                // Counter parks at the threshold; the fired flag blocks repeats.
                if (r_deb_cnt != (DEBOUNCE_CYCLES - 20'd1)) begin
                    r_deb_cnt <= r_deb_cnt + 20'd1;
                end
                if (w_btn_req) begin
                    r_deb_fired <= 1'b1;
                end
            end
        end
    end

    assign w_btn_req = r_btn_sync && !r_deb_fired &&
                       (r_deb_cnt == (DEBOUNCE_CYCLES - 20'd1));

    // Write-enable edge detector: a word held for several cycles writes once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we_prev <= 1'b0;
        end else begin
            r_we_prev <= uart_write_enable;
        end
    end

    assign w_wr_edge = uart_write_enable && !r_we_prev;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_RUN;
            r_hold_cnt      <= '0;
            r_por_hold      <= 1'b1;
            r_uart_disable  <= 1'b1;
            r_imem_we       <= 1'b0;
            r_dmem_we       <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_data      <= '0;
            r_cpu_rst       <= 1'b1;
            r_upload_active <= 1'b0;
            r_word_count    <= '0;
        end else begin
            r_state         <= w_state_nx;
            r_hold_cnt      <= w_hold_cnt_nx;
            r_por_hold      <= w_por_hold_nx;
            r_uart_disable  <= w_uart_disable_nx;
            r_imem_we       <= w_imem_we_nx;
            r_dmem_we       <= w_dmem_we_nx;
            r_mem_addr      <= w_mem_addr_nx;
            r_mem_data      <= w_mem_data_nx;
            r_cpu_rst       <= w_cpu_rst_nx;
            r_upload_active <= w_upload_active_nx;
            r_word_count    <= w_word_count_nx;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nx        = r_state;
        w_hold_cnt_nx     = r_hold_cnt;
        w_por_hold_nx     = r_por_hold;
        w_uart_disable_nx = r_uart_disable;
        w_imem_we_nx      = 1'b0;
        w_dmem_we_nx      = 1'b0;
        w_mem_addr_nx     = r_mem_addr;
        w_mem_data_nx     = r_mem_data;
        w_cpu_rst_nx      = r_cpu_rst;
        w_word_count_nx   = r_word_count;

        case (r_state)
            ST_RUN: begin
                w_uart_disable_nx = 1'b1;
                // After reset the CPU is still held until the power-on hold expires.
                if (r_por_hold) begin
                    w_hold_cnt_nx = r_hold_cnt + 8'd1;
                    if (r_hold_cnt == (CPU_RST_HOLD - 8'd1)) begin
                        w_cpu_rst_nx  = 1'b0;
                        w_por_hold_nx = 1'b0;
                        w_hold_cnt_nx = '0;
                    end
                end else begin
                    w_cpu_rst_nx = 1'b0;
                end
                if (w_btn_req) begin
                    w_state_nx        = ST_UPLOAD;
                    w_word_count_nx   = '0;
                    w_cpu_rst_nx      = 1'b1;
                    w_uart_disable_nx = 1'b0;
                    w_por_hold_nx     = 1'b0;
                    w_hold_cnt_nx     = '0;
                end
            end
            ST_UPLOAD: begin
                // An edge coincident with uart_complete is still committed.
                if (w_wr_edge) begin
                    w_imem_we_nx  = !uart_addr[RAM_DEPTH];
                    w_dmem_we_nx  = uart_addr[RAM_DEPTH];
                    w_mem_addr_nx = uart_addr[RAM_DEPTH-1:0];
                    w_mem_data_nx = uart_data;
                    if (r_word_count != 16'hFFFF) begin
                        w_word_count_nx = r_word_count + 16'd1;
                    end
                end
                if (uart_complete) begin
                    w_state_nx        = ST_DRAIN;
                    w_uart_disable_nx = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_state_nx        = ST_HOLD;
                w_hold_cnt_nx     = '0;
                w_uart_disable_nx = 1'b1;
            end
            ST_HOLD: begin
                w_hold_cnt_nx = r_hold_cnt + 8'd1;
                if (r_hold_cnt == (CPU_RST_HOLD - 8'd1)) begin
                    w_state_nx    = ST_RUN;
                    w_cpu_rst_nx  = 1'b0;
                    w_hold_cnt_nx = '0;
                end
            end
            default: begin
                w_state_nx = ST_RUN;
            end
        endcase

        w_upload_active_nx = (w_state_nx == ST_UPLOAD) || (w_state_nx == ST_DRAIN);
    end

    assign uart_disable  = r_uart_disable;
    assign imem_we       = r_imem_we;
    assign dmem_we       = r_dmem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_data      = r_mem_data;
    assign cpu_rst       = r_cpu_rst;
    assign upload_active = r_upload_active;
    assign word_count    = r_word_count;

endmodule

// File: tb/tb_uart_upload_controller.sv
// Self-checking bench for uart_upload_controller: scoreboard of expected
// memory writes checked by a monitor, plus directed mode/timing checks.
module tb_uart_upload_controller;

    localparam int unsigned RD = 14;
    localparam int unsigned IW = 32;
    localparam int unsigned HOLD = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode_btn;
    logic          uart_write_enable;
    logic [RD:0]   uart_addr;
    logic [IW-1:0] uart_data;
    logic          uart_complete;
    logic          uart_disable;
    logic          imem_we;
    logic          dmem_we;
    logic [RD-1:0] mem_addr;
    logic [IW-1:0] mem_data;
    logic          cpu_rst;
    logic          upload_active;
    logic [15:0]   word_count;

    always #5 clk = ~clk;

    uart_upload_controller #(
        .RAM_DEPTH(RD),
        .ISA_WIDTH(IW),
        .DEBOUNCE_CYCLES(20'd8),
        .CPU_RST_HOLD(8'd16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mode_btn(mode_btn),
        .uart_write_enable(uart_write_enable),
        .uart_addr(uart_addr),
        .uart_data(uart_data),
        .uart_complete(uart_complete),
        .uart_disable(uart_disable),
        .imem_we(imem_we),
        .dmem_we(dmem_we),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .cpu_rst(cpu_rst),
        .upload_active(upload_active),
        .word_count(word_count)
    );

    typedef struct packed {
        logic          dmem;
        logic [RD-1:0] addr;
        logic [IW-1:0] data;
        logic [15:0]   cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    bit          m_upload = 1'b0;
    int unsigned m_count = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (imem_we || dmem_we)) begin
            chk("strobe_exclusive", 64'(imem_we & dmem_we), 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe imem=%0b dmem=%0b addr=%0h", imem_we, dmem_we, mem_addr);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_sel", 64'(dmem_we), 64'(e.dmem));
                chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                chk("mem_data", 64'(mem_data), 64'(e.data));
                chk("word_count", 64'(word_count), 64'(e.cnt));
            end
        end
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one word; the model commits it only while in upload mode.
    task automatic send_word(input logic [RD:0] a, input logic [IW-1:0] d,
                             input int hold, input bit complete);
        exp_t e;
        tick(1);
        uart_write_enable = 1'b1;
        uart_addr         = a;
        uart_data         = d;
        uart_complete     = complete;
        if (m_upload) begin
            if (m_count < 32'hFFFF) m_count++;
            e.dmem = a[RD];
            e.addr = a[RD-1:0];
            e.data = d;
            e.cnt  = 16'(m_count);
            exp_q.push_back(e);
            if (complete) m_upload = 1'b0;
        end
        tick(hold);
        uart_write_enable = 1'b0;
        uart_complete     = 1'b0;
    endtask

    // Called just after rst_n rises (1 time unit past a clock edge).
    task automatic check_por(input string tag);
        int n = 0;
        @(negedge clk);
        while (cpu_rst && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_cpu_rst_cycles"}, 64'(n), 64'(HOLD));
        chk({tag, "_uart_disable"}, 64'(uart_disable), 64'd1);
        chk({tag, "_upload_active"}, 64'(upload_active), 64'd0);
    endtask

    // Hold the button and expect UPLOAD after 2 sync + 8 debounce + 1 register cycles.
    task automatic enter_upload();
        int n = 0;
        tick(1);
        mode_btn = 1'b1;
        while (!upload_active && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("upload_latency", 64'(n), 64'd11);
        chk("upload_uart_disable", 64'(uart_disable), 64'd0);
        chk("upload_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("upload_word_count", 64'(word_count), 64'd0);
        m_upload = 1'b1;
        m_count  = 0;
        tick(1);
        mode_btn = 1'b0;
    endtask

    initial begin
        int n;
        rst_n             = 1'b0;
        mode_btn          = 1'b0;
        uart_write_enable = 1'b0;
        uart_addr         = '0;
        uart_data         = '0;
        uart_complete     = 1'b0;

        // Reset values.
        #23;
        chk("rst_uart_disable", 64'(uart_disable), 64'd1);
        chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("rst_strobes", 64'({imem_we, dmem_we}), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_data", 64'(mem_data), 64'd0);
        chk("rst_word_count", 64'(word_count), 64'd0);
        chk("rst_upload_active", 64'(upload_active), 64'd0);
        tick(1);
        rst_n = 1'b1;
        check_por("por");

        // Writes while in RUN are ignored.
        send_word(15'h0123, 32'h1111_2222, 1, 1'b0);

        // A 5-cycle glitch must not start an upload.
        tick(1);
        mode_btn = 1'b1;
        tick(5);
        mode_btn = 1'b0;
        tick(15);
        chk("glitch_upload_active", 64'(upload_active), 64'd0);
        chk("glitch_uart_disable", 64'(uart_disable), 64'd1);
        chk("glitch_cpu_rst", 64'(cpu_rst), 64'd0);

        enter_upload();

        // Directed imem and dmem words; held enable must write once.
        send_word(15'h0004, 32'hDEADBEEF, 3, 1'b0);
        send_word(15'h4010, 32'h0000_00A5, 2, 1'b0);

        // Randomised words.
        for (int i = 0; i < 12; i++) begin
            send_word(15'($urandom_range(0, 32767)), $urandom,
                      int'($urandom_range(1, 4)), 1'b0);
            tick(int'($urandom_range(0, 2)));
        end

        // Final word coincident with completion, then DRAIN and HOLD.
        send_word(15'h4ABC, 32'hCAFE_F00D, 1, 1'b1);
        @(negedge clk);
        chk("drain_upload_active", 64'(upload_active), 64'd1);
        chk("drain_uart_disable", 64'(uart_disable), 64'd1);
        chk("drain_cpu_rst", 64'(cpu_rst), 64'd1);
        @(negedge clk);
        chk("hold_upload_active", 64'(upload_active), 64'd0);
        n = 0;
        while (cpu_rst && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("hold_cycles", 64'(n), 64'(HOLD));
        chk("run_uart_disable", 64'(uart_disable), 64'd1);
        chk("run_word_count", 64'(word_count), 64'(m_count));
        chk("upload_queue_drained", 64'(exp_q.size()), 64'd0);

        // Writes after the upload are ignored.
        send_word(15'h0042, 32'h5555_AAAA, 2, 1'b0);

        // Second upload aborted by reset after two words.
        enter_upload();
        send_word(15'($urandom_range(0, 16383)), $urandom, 1, 1'b0);
        send_word(15'($urandom_range(16384, 32767)), $urandom, 2, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        m_upload = 1'b0;
        m_count  = 0;
        #1;
        chk("abort_uart_disable", 64'(uart_disable), 64'd1);
        chk("abort_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("abort_word_count", 64'(word_count), 64'd0);
        chk("abort_mem_addr", 64'(mem_addr), 64'd0);
        chk("abort_mem_data", 64'(mem_data), 64'd0);
        chk("abort_upload_active", 64'(upload_active), 64'd0);
        tick(3);
        rst_n = 1'b1;
        check_por("abort");

        tick(5);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
